sd_dat_tx: RTL
==============

Name: sd_dat_tx

Overview:
SD DAT-line write transmitter, the transmit counterpart of the existing DAT receiver in the SD host. It sends one or more data blocks from the TX FIFO on DAT[3:0] in 1-bit or 4-bit mode: start bit, data, per-line CRC16 and end bit. It then receives the card's CRC status token and waits for the card to release busy before the next block. It is timed by the shared SD clock strobes and is controlled by the SD command/register logic.

Parameters:
STATUS_TIMEOUT, 64, rising strobes allowed in STATUS_WAIT before the status start bit is seen.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_sd_clk_strobe_rising  in  1  one-cycle pulse at SD clock rising edge; card samples here
i_sd_clk_strobe_falling  in  1  one-cycle pulse at SD clock falling edge; host drives here
i_sd_dat  in  4  synchronized DAT pin inputs
o_sd_dat_oe  out  4  per-line output enable
o_sd_dat_out  out  4  DAT drive values
i_dat_width  in  1  0 = 1-bit (DAT0), 1 = 4-bit
i_dat_block_size  in  7  words per block minus 1
i_dat_num_blocks  in  8  blocks minus 1
i_dat_start  in  1  start transfer
i_dat_stop  in  1  abort
o_dat_busy  out  1  not IDLE
o_dat_crc_error  out  1  card status token != 3'b010
o_dat_underrun  out  1  FIFO empty when a word was needed
o_dat_timeout  out  1  no status token
i_tx_fifo_empty  in  1  TX FIFO empty
o_tx_fifo_pop  out  1  one-cycle pop
i_tx_fifo_data  in  32  FIFO head word, MSB transmitted first

Behaviour:
- Reset values: o_sd_dat_oe=0, o_sd_dat_out=4'hF, o_tx_fifo_pop=0, all error outputs 0, state IDLE.
- Active lines: width 4 -> 4'hF; width 1 -> 4'h1. OE and drive apply only to active lines.
- IDLE: i_dat_start -> WAIT_DATA. On that cycle, clear all error flags and load the block counter = i_dat_num_blocks. i_dat_start is ignored outside IDLE.
- WAIT_DATA: OE=0. On a falling strobe with !i_tx_fifo_empty, drive the start bit (0) with OE on, then go to START. With the FIFO empty, wait indefinitely.
- START: on the next falling strobe, pop the first word and drive its top 4 bits (4-bit) or bit 31 (1-bit). Load the data bit counter = (block_size+1)*8 or *32, 13 bits wide. Go to TX_DATA.
- TX_DATA: each falling strobe shifts out the next bits. At the strobe that drives the first bits of each later word, pop that word (o_tx_fifo_pop high for exactly one i_clk cycle).
- Underrun: if i_tx_fifo_empty at a pop strobe, set o_dat_underrun, OE=0 and go to IDLE.
- After the last data bits, the next falling strobe drives CRC bit 15 on each active line and goes to TX_CRC.
- CRC: four CRC16 generators shift on rising strobes in TX_DATA, each taking its own o_sd_dat_out[i] as input. They are reset in WAIT_DATA. Their values are latched into 16-bit shift registers at the TX_DATA->TX_CRC strobe.
- TX_CRC: 16 bits, MSB first. The falling strobe after bit 0 drives the end bit (1) and goes to TX_END.
- TX_END: the next falling strobe sets OE=0 and goes to STATUS_WAIT; the timeout counter is cleared.
- STATUS_WAIT: on each rising strobe, i_sd_dat[0]==0 -> STATUS_RX. Otherwise increment the counter; when it reaches STATUS_TIMEOUT, set o_dat_timeout and go to IDLE.
- STATUS_RX: sample 3 status bits then the end bit on rising strobes. Status != 3'b010 -> set o_dat_crc_error and go to IDLE. Otherwise go to BUSY.
- BUSY: on a rising strobe with i_sd_dat[0]==1: block counter 0 -> IDLE; else decrement and go to WAIT_DATA. BUSY has no timeout.
- i_dat_stop: highest priority in every state. Go to IDLE next cycle with OE=0 and no pop; errors are unchanged. Simultaneous start+stop in IDLE stays IDLE.
- o_dat_busy = state != IDLE.

Decomposition:
- Shared sd package: state enum, STATUS_OK = 3'b010, TX bit-count widths.
- Reuse the existing sd_crc_16 generator, 4 instances. No other sub-module.

Test Plan:
- 4-bit, block_size=0, num_blocks=0, FIFO word 32'h12345678, card status 010, busy 3 clocks -> DAT nibbles after start bit are 1,2,…,8; per-line CRC16 matches model; end bit 1; one pop; busy deasserts after DAT0 high.
- 1-bit, block_size=127 (512 B), num_blocks=1 -> 2×(1+4096+16+1) bits on DAT0 only; OE=4'h1; 256 pops; DAT[3:1] never driven.
- Card returns status 101 -> o_dat_crc_error=1, IDLE, no second block started.
- FIFO empties after 3 of 4 words -> o_dat_underrun=1 at the 4th-word strobe, OE=0 next cycle, exactly 3 pops.
- DAT0 held high after end bit -> o_dat_timeout=1 after 64 rising strobes; i_dat_stop asserted mid-TX_DATA -> IDLE and OE=0 next cycle.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD host definitions: DAT transmitter states, status token, CRC polynomial and
// helpers for splitting FIFO words onto the DAT lines.
package sd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWaitData,
    StStart,
    StTxData,
    StTxCrc,
    StTxEnd,
    StStatusWait,
    StStatusRx,
    StBusy
  } sd_dat_tx_state_e;

  localparam logic [2:0]  STATUS_OK    = 3'b010;
  localparam int unsigned TX_BIT_CNT_W = 13;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;

  function automatic logic [3:0] active_lines(input logic width);
    return width ? 4'hF : 4'h1;
  endfunction

  // Bits put on the lines for the head of a word; unused lines idle high.
  function automatic logic [3:0] lead_bits(input logic [31:0] word, input logic width);
    return width ? word[31:28] : {3'b111, word[31]};
  endfunction

  function automatic logic [31:0] shift_word(input logic [31:0] word, input logic width);
    return width ? {word[27:0], 4'h0} : {word[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/sd_crc_16.sv
// Serial CRC16-CCITT generator for one SD DAT line (x^16 + x^12 + x^5 + 1, zero seed).
module sd_crc_16
  import sd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] crc_q;
  logic        feedback;

  assign feedback = i_bit ^ crc_q[15];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      crc_q <= '0;
    end else if (i_enable) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/sd_dat_tx.sv
// SD DAT-line write transmitter: streams FIFO blocks with per-line CRC16, then collects
// the card's CRC status token and waits for busy release before the next block.
module sd_dat_tx
  import sd_pkg::*;
#(
  parameter int unsigned STATUS_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe_rising,
  input  logic        i_sd_clk_strobe_falling,
  input  logic [3:0]  i_sd_dat,
  output logic [3:0]  o_sd_dat_oe,
  output logic [3:0]  o_sd_dat_out,
  input  logic        i_dat_width,
  input  logic [6:0]  i_dat_block_size,
  input  logic [7:0]  i_dat_num_blocks,
  input  logic        i_dat_start,
  input  logic        i_dat_stop,
  output logic        o_dat_busy,
  output logic        o_dat_crc_error,
  output logic        o_dat_underrun,
  output logic        o_dat_timeout,
  input  logic        i_tx_fifo_empty,
  output logic        o_tx_fifo_pop,
  input  logic [31:0] i_tx_fifo_data
);

  localparam int unsigned TmoW = $clog2(STATUS_TIMEOUT + 1);

  sd_dat_tx_state_e        state_q, state_d;
  logic [3:0]              oe_q, oe_d, dat_q, dat_d;
  logic [31:0]             sr_q, sr_d;
  logic [TX_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_m1;
  logic [3:0]              crc_cnt_q, crc_cnt_d;
  logic [3:0][15:0]        crc_sr_q, crc_sr_d;
  logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [1:0]              stat_cnt_q, stat_cnt_d;
  logic [2:0]              status_q, status_d;
  logic [7:0]              blk_cnt_q, blk_cnt_d;
  logic                    crc_err_q, crc_err_d, underrun_q, underrun_d, timeout_q, timeout_d;
  logic                    pop, need_word, word_start, crc_clear, crc_en;
  logic [3:0]              active;
  logic [7:0]              blk_words;
  logic [15:0]             crc_val [4];
  logic                    unused_dat;

  assign unused_dat = ^i_sd_dat[3:1];
  assign active     = active_lines(i_dat_width);
  assign blk_words  = {1'b0, i_dat_block_size} + 8'd1;
  assign bit_cnt_m1 = bit_cnt_q - 1'b1;
  // A new word begins every 8 strobes in 4-bit mode and every 32 in 1-bit mode.
  assign word_start = i_dat_width ? (bit_cnt_m1[2:0] == 3'd0) : (bit_cnt_m1[4:0] == 5'd0);

  for (genvar g = 0; g < 4; g++) begin : g_crc
    sd_crc_16 u_crc (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (crc_clear),
      .i_enable (crc_en),
      .i_bit    (dat_q[g]),
      .o_crc    (crc_val[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    oe_d       = oe_q;
    dat_d      = dat_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    crc_sr_d   = crc_sr_q;
    tmo_cnt_d  = tmo_cnt_q;
    stat_cnt_d = stat_cnt_q;
    status_d   = status_q;
    blk_cnt_d  = blk_cnt_q;
    crc_err_d  = crc_err_q;
    underrun_d = underrun_q;
    timeout_d  = timeout_q;
    pop        = 1'b0;
    need_word  = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;

    if (i_dat_stop) begin
      state_d = StIdle;
      oe_d    = 4'h0;
      dat_d   = 4'hF;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_dat_start) begin
            state_d    = StWaitData;
            crc_err_d  = 1'b0;
            underrun_d = 1'b0;
            timeout_d  = 1'b0;
            blk_cnt_d  = i_dat_num_blocks;
          end
        end
        StWaitData: begin
          crc_clear = 1'b1;
          oe_d      = 4'h0;
          if (i_sd_clk_strobe_falling && !i_tx_fifo_empty) begin
            dat_d   = ~active;
            oe_d    = active;
            state_d = StStart;
          end
        end
        StStart: begin
          if (i_sd_clk_strobe_falling) begin
            need_word = 1'b1;
            bit_cnt_d = i_dat_width ? {2'b00, blk_words, 3'b000} : {blk_words, 5'b00000};
            state_d   = StTxData;
          end
        end
        StTxData: begin
          crc_en = i_sd_clk_strobe_rising;
          if (i_sd_clk_strobe_falling) begin
            if (bit_cnt_q == TX_BIT_CNT_W'(1)) begin
              for (int i = 0; i < 4; i++) begin
                crc_sr_d[i] = {crc_val[i][14:0], 1'b0};
                dat_d[i]    = active[i] ? crc_val[i][15] : 1'b1;
              end
              crc_cnt_d = 4'd0;
              state_d   = StTxCrc;
            end else begin
              bit_cnt_d = bit_cnt_m1;
              if (word_start) begin
                need_word = 1'b1;
              end else begin
                dat_d = lead_bits(sr_q, i_dat_width);
                sr_d  = shift_word(sr_q, i_dat_width);
              end
            end
          end
        end
        StTxCrc: begin
          if (i_sd_clk_strobe_falling) begin
            if (crc_cnt_q == 4'd15) begin
              dat_d   = 4'hF;
              state_d = StTxEnd;
            end else begin
              for (int i = 0; i < 4; i++) begin
                dat_d[i]    = active[i] ? crc_sr_q[i][15] : 1'b1;
                crc_sr_d[i] = {crc_sr_q[i][14:0], 1'b0};
              end
              crc_cnt_d = crc_cnt_q + 4'd1;
            end
          end
        end
        StTxEnd: begin
          if (i_sd_clk_strobe_falling) begin
            oe_d      = 4'h0;
            tmo_cnt_d = '0;
            state_d   = StStatusWait;
          end
        end
        StStatusWait: begin
          if (i_sd_clk_strobe_rising) begin
            if (!i_sd_dat[0]) begin
              stat_cnt_d = 2'd0;
              state_d    = StStatusRx;
            end else if (tmo_cnt_q == TmoW'(STATUS_TIMEOUT - 1)) begin
              timeout_d = 1'b1;
              state_d   = StIdle;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
        end
        StStatusRx: begin
          if (i_sd_clk_strobe_rising) begin
            if (stat_cnt_q == 2'd3) begin
              if (status_q != STATUS_OK) begin
                crc_err_d = 1'b1;
                state_d   = StIdle;
              end else begin
                state_d = StBusy;
              end
            end else begin
              status_d   = {status_q[1:0], i_sd_dat[0]};
              stat_cnt_d = stat_cnt_q + 2'd1;
            end
          end
        end
        StBusy: begin
          if (i_sd_clk_strobe_rising && i_sd_dat[0]) begin
            if (blk_cnt_q == 8'd0) begin
              state_d = StIdle;
            end else begin
              blk_cnt_d = blk_cnt_q - 8'd1;
              state_d   = StWaitData;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      // Word fetch shared by the first word (START) and later words (TX_DATA).
      if (need_word) begin
        if (i_tx_fifo_empty) begin
          underrun_d = 1'b1;
          oe_d       = 4'h0;
          dat_d      = 4'hF;
          state_d    = StIdle;
        end else begin
          pop   = 1'b1;
          dat_d = lead_bits(i_tx_fifo_data, i_dat_width);
          sr_d  = shift_word(i_tx_fifo_data, i_dat_width);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      oe_q       <= 4'h0;
      dat_q      <= 4'hF;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      crc_sr_q   <= '0;
      tmo_cnt_q  <= '0;
      stat_cnt_q <= '0;
      status_q   <= '0;
      blk_cnt_q  <= '0;
      crc_err_q  <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      dat_q      <= dat_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      crc_sr_q   <= crc_sr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stat_cnt_q <= stat_cnt_d;
      status_q   <= status_d;
      blk_cnt_q  <= blk_cnt_d;
      crc_err_q  <= crc_err_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_sd_dat_oe     = oe_q;
  assign o_sd_dat_out    = dat_q;
  assign o_tx_fifo_pop   = pop;
  assign o_dat_busy      = (state_q != StIdle);
  assign o_dat_crc_error = crc_err_q;
  assign o_dat_underrun  = underrun_q;
  assign o_dat_timeout   = timeout_q;

endmodule
